text_write_ctrl: RTL and testbench

Sequences all writes into the character text RAM that feeds the VGA text renderer. Takes received UART bytes and a clear request, and issues single-cycle cell writes to the RAM write port. It tracks the cursor through newline, backspace and wrap-around. It owns the write port exclusively: UART traffic and the screen-clear sweep are arbitrated here, with a one-byte holding buffer so a byte arriving during a clear is not lost.

---
 rtl/text_ctrl_pkg.sv | 36 +++
 rtl/cell_sweep_counter.sv | 60 ++++++
 rtl/text_write_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_text_write_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_ctrl_pkg.sv
// Shared constants and enums for the text RAM write controller.
package text_ctrl_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] PRINT_LO   = 8'h20;
    localparam logic [7:0] PRINT_HI   = 8'h7E;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    typedef enum logic [1:0] {
        CLS_PRINT,
        CLS_NL,
        CLS_BS,
        CLS_IGN
    } byte_class_e;

    // Sort a received byte into the handful of classes the controller acts on.
    function automatic byte_class_e classify_byte(input logic [7:0] b);
        if (b >= PRINT_LO && b <= PRINT_HI) begin
            return CLS_PRINT;
        end else if (b == CHAR_CR || b == CHAR_LF) begin
            return CLS_NL;
        end else if (b == CHAR_BS) begin
            return CLS_BS;
        end else begin
            return CLS_IGN;
        end
    endfunction

endpackage

// File: rtl/cell_sweep_counter.sv
// Row/column cell counter with row-major wrap. It is the cursor during
// normal text entry and the address generator during a screen clear.
module cell_sweep_counter #(
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS),
    parameter int HOME_ROW = 1,
    parameter int HOME_COL = 0
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [ROW_W-1:0] load_row_i,
    input  logic [COL_W-1:0] load_col_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // Next position: an explicit load beats a step; a step wraps col then row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (load_i) begin
            row_d = load_row_i;
            col_d = load_col_i;
        end else if (step_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position register; reset parks it at the home cell.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= ROW_W'(HOME_ROW);
            col_q <= COL_W'(HOME_COL);
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/text_write_ctrl.sv
// Text RAM write sequencer: turns UART bytes into cell writes, tracks the
// cursor, and runs the screen-clear sweep with a one-byte holding buffer.
module text_write_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 4,
    parameter int COL_W    = $clog2(COLS),
    parameter int ROW_W    = $clog2(ROWS),
    parameter int HOME_ROW = 1,
    parameter int HOME_COL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             clear_req,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             overflow
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             overflow_q, overflow_d;
    logic             ram_we_q, ram_we_d;
    logic [ROW_W-1:0] ram_row_q, ram_row_d;
    logic [COL_W-1:0] ram_col_q, ram_col_d;
    logic [7:0]       ram_wdata_q, ram_wdata_d;

    logic             cnt_step;
    logic             cnt_load;
    logic [ROW_W-1:0] cnt_load_row;
    logic [COL_W-1:0] cnt_load_col;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             cur_last;

    logic             proc_vld;
    logic [7:0]       proc_byte;

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
        return (r == ROW_LAST) ? '0 : r + ROW_W'(1);
    endfunction

    cell_sweep_counter #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W),
        .HOME_ROW (HOME_ROW),
        .HOME_COL (HOME_COL)
    ) u_cursor (
        .clk        (clk),
        .rst_ni     (reset),
        .step_i     (cnt_step),
        .load_i     (cnt_load),
        .load_row_i (cnt_load_row),
        .load_col_i (cnt_load_col),
        .row_o      (cur_row),
        .col_o      (cur_col),
        .last_o     (cur_last)
    );

    // Arbitrate the write port between byte handling and the clear sweep.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pend_vld_d   = pend_vld_q;
        pend_data_d  = pend_data_q;
        overflow_d   = overflow_q;
        ram_we_d     = 1'b0;
        ram_row_d    = ram_row_q;
        ram_col_d    = ram_col_q;
        ram_wdata_d  = ram_wdata_q;
        cnt_step     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_row = cur_row;
        cnt_load_col = cur_col;
        proc_vld     = 1'b0;
        proc_byte    = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    // Cell (0,0) is written on entry so the sweep spans exactly
                    // the busy window; the counter resumes at (0,1).
                    state_d      = CLEAR;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    ram_we_d     = 1'b1;
                    ram_row_d    = '0;
                    ram_col_d    = '0;
                    ram_wdata_d  = CHAR_SPACE;
                    cnt_load     = 1'b1;
                    cnt_load_row = '0;
                    cnt_load_col = COL_W'(1);
                    if (rx_valid) begin
                        if (pend_vld_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            pend_vld_d  = 1'b1;
                            pend_data_d = rx_data;
                        end
                    end
                end else begin
                    // The held byte is older, so it goes first; a live byte
                    // arriving now takes the slot it frees.
                    if (pend_vld_q) begin
                        proc_vld   = 1'b1;
                        proc_byte  = pend_data_q;
                        pend_vld_d = rx_valid;
                        if (rx_valid) begin
                            pend_data_d = rx_data;
                        end
                    end else if (rx_valid) begin
                        proc_vld  = 1'b1;
                        proc_byte = rx_data;
                    end

                    if (proc_vld) begin
                        unique case (classify_byte(proc_byte))
                            CLS_PRINT: begin
                                ram_we_d    = 1'b1;
                                ram_row_d   = cur_row;
                                ram_col_d   = cur_col;
                                ram_wdata_d = proc_byte;
                                cnt_step    = 1'b1;
                            end
                            CLS_NL: begin
                                cnt_load     = 1'b1;
                                cnt_load_row = next_row(cur_row);
                                cnt_load_col = '0;
                            end
                            CLS_BS: begin
                                if (cur_col != '0) begin
                                    ram_we_d     = 1'b1;
                                    ram_row_d    = cur_row;
                                    ram_col_d    = cur_col - COL_W'(1);
                                    ram_wdata_d  = CHAR_SPACE;
                                    cnt_load     = 1'b1;
                                    cnt_load_row = cur_row;
                                    cnt_load_col = cur_col - COL_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            CLEAR: begin
                if (rx_valid) begin
                    if (pend_vld_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = rx_data;
                    end
                end
                if (done_q) begin
                    // One idle beat after the last write so busy covers only the sweep.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_row_d   = cur_row;
                    ram_col_d   = cur_col;
                    ram_wdata_d = CHAR_SPACE;
                    if (cur_last) begin
                        cnt_load     = 1'b1;
                        cnt_load_row = ROW_W'(HOME_ROW);
                        cnt_load_col = COL_W'(HOME_COL);
                        done_d       = 1'b1;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= 8'h00;
            overflow_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_row_q   <= '0;
            ram_col_q   <= '0;
            ram_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            overflow_q  <= overflow_d;
            ram_we_q    <= ram_we_d;
            ram_row_q   <= ram_row_d;
            ram_col_q   <= ram_col_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_row    = ram_row_q;
    assign ram_col    = ram_col_q;
    assign ram_wdata  = ram_wdata_q;
    assign cursor_row = cur_row;
    assign cursor_col = cur_col;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl: directed scenarios plus a random
// byte/clear stream, all checked against a screen-level reference model.
module tb_text_write_ctrl;

    localparam int COLS     = 32;
    localparam int ROWS     = 4;
    localparam int COL_W    = 5;
    localparam int ROW_W    = 2;
    localparam int HOME_ROW = 1;
    localparam int HOME_COL = 0;
    localparam int CELLS    = COLS * ROWS;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             clear_req;
    logic             ram_we;
    logic [ROW_W-1:0] ram_row;
    logic [COL_W-1:0] ram_col;
    logic [7:0]       ram_wdata;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             busy;
    logic             overflow;

    always #5 clk = ~clk;

    text_write_ctrl #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .HOME_ROW (HOME_ROW),
        .HOME_COL (HOME_COL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .clear_req  (clear_req),
        .ram_we     (ram_we),
        .ram_row    (ram_row),
        .ram_col    (ram_col),
        .ram_wdata  (ram_wdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model: cursor, one-entry holding queue, sweep progress,
    // and the write expected on the most recent clock edge.
    int         m_r, m_c, m_ovf, m_sweep_left, m_sweep_idx;
    logic [7:0] m_pend[$];
    bit         e_we;
    int         e_row, e_col, e_data;

    function automatic void m_reset();
        m_r = HOME_ROW;
        m_c = HOME_COL;
        m_ovf = 0;
        m_sweep_left = 0;
        m_sweep_idx = 0;
        m_pend.delete();
        e_we = 1'b0;
    endfunction

    function automatic void m_write(input int r, input int c, input int d);
        e_we = 1'b1;
        e_row = r;
        e_col = c;
        e_data = d;
    endfunction

    function automatic void m_hold(input logic [7:0] d);
        if (m_pend.size() == 0) m_pend.push_back(d);
        else m_ovf = 1;
    endfunction

    function automatic void m_apply(input logic [7:0] b);
        int pos;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_write(m_r, m_c, int'(b));
            pos = (m_r * COLS + m_c + 1) % CELLS;
            m_r = pos / COLS;
            m_c = pos % COLS;
        end else if (b == 8'h0D || b == 8'h0A) begin
            m_r = (m_r + 1) % ROWS;
            m_c = 0;
        end else if (b == 8'h08) begin
            if (m_c > 0) begin
                m_c = m_c - 1;
                m_write(m_r, m_c, 32'h20);
            end
        end
    endfunction

    function automatic void m_edge(input bit v, input logic [7:0] d, input bit c);
        logic [7:0] b;
        e_we = 1'b0;
        if (m_sweep_left > 0) begin
            if (v) m_hold(d);
            if (m_sweep_idx < CELLS) begin
                m_write(m_sweep_idx / COLS, m_sweep_idx % COLS, 32'h20);
                m_sweep_idx++;
            end
            m_sweep_left--;
        end else if (c) begin
            if (v) m_hold(d);
            m_write(0, 0, 32'h20);
            m_sweep_idx = 1;
            m_sweep_left = CELLS;
            m_r = HOME_ROW;
            m_c = HOME_COL;
        end else if (m_pend.size() > 0) begin
            b = m_pend.pop_front();
            if (v) m_pend.push_back(d);
            m_apply(b);
        end else if (v) begin
            m_apply(d);
        end
    endfunction

    task automatic compare_outputs();
        check_eq("ram_we", int'(ram_we), int'(e_we));
        if (e_we) begin
            check_eq("ram_row", int'(ram_row), e_row);
            check_eq("ram_col", int'(ram_col), e_col);
            check_eq("ram_wdata", int'(ram_wdata), e_data);
        end
        check_eq("busy", int'(busy), int'(m_sweep_left > 0));
        if (m_sweep_left == 0) begin
            check_eq("cursor_row", int'(cursor_row), m_r);
            check_eq("cursor_col", int'(cursor_col), m_c);
        end
        check_eq("overflow", int'(overflow), m_ovf);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit c);
        rx_valid = v;
        rx_data = d;
        clear_req = c;
        @(posedge clk);
        m_edge(v, d, c);
        #1;
        compare_outputs();
        rx_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    // Clear starting at step 0, optional re-clear and up to two bytes during it.
    task automatic sweep(input int reclr, input int a1, input logic [7:0] d1,
                         input int a2, input logic [7:0] d2,
                         output int nb, output int nw);
        bit v;
        logic [7:0] d;
        nb = 0;
        nw = 0;
        for (int i = 0; i < 400; i++) begin
            v = (i == a1) || (i == a2);
            d = (i == a2) ? d2 : d1;
            step(v, d, (i == 0) || (i == reclr));
            if (ram_we) nw++;
            if (busy) nb++;
            else break;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 11))
            0:       return 8'h0D;
            1:       return 8'h0A;
            2, 3:    return 8'h08;
            4:       return 8'($urandom_range(128, 255));
            5:       return 8'($urandom_range(0, 31));
            6:       return 8'h7F;
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nw;
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        clear_req = 1'b0;
        m_reset();
        #22;
        check_eq("rst_ram_we", int'(ram_we), 0);
        check_eq("rst_ram_row", int'(ram_row), 0);
        check_eq("rst_ram_col", int'(ram_col), 0);
        check_eq("rst_ram_wdata", int'(ram_wdata), 0);
        check_eq("rst_cursor_row", int'(cursor_row), HOME_ROW);
        check_eq("rst_cursor_col", int'(cursor_col), HOME_COL);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;

        // First byte lands one cycle later at the home cell.
        step(1'b1, 8'h41, 1'b0);
        check_eq("first_we", int'(ram_we), 1);
        check_eq("first_data", int'(ram_wdata), 8'h41);
        check_eq("first_cursor_col", int'(cursor_col), 1);

        // Back to (1,0), fill row 1, then wrap from (3,31) to (0,0).
        step(1'b1, 8'h08, 1'b0);
        for (int i = 0; i < COLS; i++) step(1'b1, 8'(8'h61 + (i % 26)), 1'b0);
        check_eq("row_fill_cursor_row", int'(cursor_row), 2);
        check_eq("row_fill_cursor_col", int'(cursor_col), 0);
        step(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < COLS - 1; i++) step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        check_eq("wrap_cursor_row", int'(cursor_row), 0);
        check_eq("wrap_cursor_col", int'(cursor_col), 0);

        // Newline, backspace at column 0, backspace mid-row.
        step(1'b1, 8'h0A, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h2E, 1'b0);
        step(1'b1, 8'h0D, 1'b0);
        check_eq("cr_no_write", int'(ram_we), 0);
        step(1'b1, 8'h08, 1'b0);
        check_eq("bs_col0_no_write", int'(ram_we), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        check_eq("bs_write_col", int'(ram_col), 2);
        check_eq("bs_cursor_col", int'(cursor_col), 2);

        // Clear with a second request mid-sweep.
        sweep(50, -1, 8'h00, -1, 8'h00, nb, nw);
        check_eq("clr_busy_cycles", nb, CELLS);
        check_eq("clr_writes", nw, CELLS);
        check_eq("clr_cursor_row", int'(cursor_row), HOME_ROW);

        // Two bytes during a sweep: first kept, second dropped.
        sweep(-1, 10, 8'h42, 20, 8'h43, nb, nw);
        check_eq("pend_sweep_writes", nw, CELLS);
        step(1'b0, 8'h00, 1'b0);
        check_eq("pend_drain_data", int'(ram_wdata), 8'h42);
        check_eq("pend_drain_row", int'(ram_row), HOME_ROW);
        check_eq("pend_overflow", int'(overflow), 1);

        // Byte together with clear_req, then ignored codes.
        sweep(-1, 0, 8'h58, -1, 8'h00, nb, nw);
        check_eq("coinc_busy_cycles", nb, CELLS);
        step(1'b0, 8'h00, 1'b0);
        check_eq("coinc_data", int'(ram_wdata), 8'h58);
        step(1'b1, 8'h7F, 1'b0);
        step(1'b1, 8'h90, 1'b0);
        check_eq("ignored_no_write", int'(ram_we), 0);

        // Random stream with occasional clears.
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 3) != 0), rand_byte(), ($urandom_range(0, 199) == 0));
        end

        // Reset in the middle of a sweep.
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_we", int'(ram_we), 0);
        check_eq("abort_cursor_row", int'(cursor_row), HOME_ROW);
        check_eq("abort_overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h4B, 1'b0);
        step(1'b1, 8'h4C, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
